hdmi_config_sequencer: RTL and testbench
========================================

// Module: hdmi_config_sequencer
// PURPOSE
// Upstream driver for I2C_controller: walks an internal table of 16-bit {reg_addr, reg_value}
// writes for the HDMI transmitter and issues one I2C write per entry. Handles power-up delay,
// NACK/timeout retry, and re-configuration on hot-plug. Runs on the same 100 kHz clock as the
// controller; outputs connect directly to its start/register_data/slave_address inputs.
// PARAMETERS
// SLAVE_ADDR     8'h72   8-bit write address of the transmitter, driven on slave_address
// NUM_REGS       15      number of table entries sent, indices 0..NUM_REGS-1
// PWRUP_CYCLES   20000   wait after reset or HPD rise before the first write (200 ms)
// TIMEOUT_CYCLES 200     max cycles from start pulse to done; 8-bit counter
// RETRY_MAX      3       retries per entry after the first attempt, before giving up
// PORTS
// clock_100khz   in   1   system clock, shared with I2C_controller
// MR_n           in   1   asynchronous active-low reset
// hpd            in   1   hot-plug detect from connector, asynchronous
// i2c_stop       in   1   controller status; high while idle/busy, 1-cycle low pulse = transfer done
// i2c_ack        in   1   controller NACK flag; high = slave left SDA high on a 9th clock
// i2c_start      out  1   1-cycle start pulse to controller
// register_data  out  16  {reg_addr, reg_value} of current entry
// slave_address  out  8   constant SLAVE_ADDR
// reg_index      out  8   current table index
// config_done    out  1   all entries written successfully
// config_error   out  1   an entry failed after RETRY_MAX retries
// BEHAVIOUR
// - Reset: all outputs 0 except slave_address=SLAVE_ADDR; state=PWRUP; counters and retry count 0.
// - hpd passes a 2-flop synchroniser; hpd_rise = sync rising edge, stored as hpd_pend until serviced.
// - Table (combinational from reg_index): 0:4110 1:9803 2:9AE0 3:9C30 4:9D61 5:A2A4 6:A3A4 7:E0D0
//   8:F900 9:1500 10:1630 11:1702 12:1800 13:AF06 14:D6C0; index >= NUM_REGS returns 16'h0000.
// - States:
//   PWRUP: count to PWRUP_CYCLES-1 -> ISSUE, reg_index=0, retry=0. Sync hpd low: hold counter at 0.
//   ISSUE: only if i2c_stop=1: i2c_start=1 for exactly 1 cycle, clear nack_sticky and timer -> WAIT.
//   WAIT: nack_sticky|=i2c_ack each cycle; timer++. i2c_stop=0 -> CHECK. timer=TIMEOUT_CYCLES-1 -> RETRY.
//   CHECK: hpd_pend -> PWRUP (clear pend, done/error, index). nack_sticky -> RETRY.
//          else index=NUM_REGS-1 -> DONE, else index++, retry=0 -> ISSUE.
//   RETRY: retry<RETRY_MAX -> retry++, ISSUE same index; else -> ERROR.
//   DONE: config_done=1. ERROR: config_error=1. Both hold until hpd_pend -> PWRUP (flags cleared).
// - i2c_start never asserted while i2c_stop=0 nor on two consecutive cycles; controller restarts
//   on a held start, so the single-cycle rule is mandatory.
// - hpd_rise during PWRUP restarts the wait counter; during WAIT it is deferred to CHECK so a
//   transfer in flight is never abandoned (controller cannot be aborted).
// - Timeout with i2c_stop still 1: RETRY issues again only once i2c_stop=1 (controller idle).
// - register_data/reg_index stable from ISSUE until CHECK; controller latches data mid-transfer.
// - Latency: start pulse to CHECK = controller transfer time + 1; entry-to-entry gap 2 cycles.
// - MR_n low at any time: immediate return to reset values, including mid-transfer.
// TESTING
// 1 Reset, hpd=1, controller model ACKs all: after 20000 cycles start pulses, 15 transfers with
//   register_data 16'h4110..16'hD6C0 in order -> config_done=1, config_error=0, 15 start pulses.
// 2 NACK on entry 3 once -> entry 3 (16'h9C30) re-sent once, sequence completes, config_done=1.
// 3 NACK on entry 5 always -> 4 attempts at index 5, then config_error=1, no further start pulses.
// 4 Controller model never drops i2c_stop -> timeout after 200 cycles, 4 attempts, config_error=1.
// 5 hpd toggles 1->0->1 during entry 7 transfer -> transfer finishes, done/error cleared, 20000-cycle
//   wait, full sequence restarts at index 0 and completes.
// 6 MR_n pulsed low mid-WAIT -> i2c_start=0, reg_index=0, flags 0 immediately; full rerun after release.

Source files
------------

// File: rtl/hdmi_config_sequencer.sv
// hdmi_config_sequencer
// Walks a fixed table of {reg_addr, reg_value} words and hands each one to the
// I2C_controller as a single write. It waits for power-up before the first write and
// retries an entry after a NACK or a timeout. A hot-plug rise restarts the whole table.
//
// Handshake with the controller:
//   - i2c_start is a one-cycle pulse. It is raised only in ISSUE, and only while i2c_stop=1.
//   - i2c_stop is high while the controller is idle or busy.
//   - A one-cycle low pulse on i2c_stop marks the end of the transfer.
//   - i2c_ack is sampled on every WAIT cycle. A high level on any of those cycles marks
//     the transfer as NACKed.
//   - register_data and reg_index do not change from ISSUE until CHECK, because the
//     controller latches them mid-transfer.
module hdmi_config_sequencer #(
    parameter logic [7:0] SLAVE_ADDR     = 8'h72,
    parameter int         NUM_REGS       = 15,
    parameter int         PWRUP_CYCLES   = 20000,
    parameter int         TIMEOUT_CYCLES = 200,
    parameter int         RETRY_MAX      = 3
) (
    input  logic        clock_100khz,
    input  logic        MR_n,
    input  logic        hpd,
    input  logic        i2c_stop,
    input  logic        i2c_ack,
    output logic        i2c_start,
    output logic [15:0] register_data,
    output logic [7:0]  slave_address,
    output logic [7:0]  reg_index,
    output logic        config_done,
    output logic        config_error,
    output logic [2:0]  fsm_state
);

    localparam int CW = $clog2(PWRUP_CYCLES + 1);
    localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

    localparam logic [CW-1:0] PWR_LAST = CW'(PWRUP_CYCLES - 1);
    localparam logic [7:0]    TO_LAST  = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    IDX_LAST = 8'(NUM_REGS - 1);
    localparam logic [8:0]    NREG     = 9'(NUM_REGS);
    localparam logic [RW-1:0] RMAX     = RW'(RETRY_MAX);

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_RETRY = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] pwr_cnt, pwr_cnt_d;
    logic [7:0]    timer, timer_d;
    logic [RW-1:0] retry, retry_d;
    logic [7:0]    index_d;
    logic          nack_sticky, nack_d;
    logic          hpd_s1, hpd_s2, hpd_q;
    logic          hpd_pend, pend_d;
    logic          hpd_rise;
    logic [15:0]   table_word;

    assign hpd_rise = hpd_s2 & ~hpd_q;

    // Register table, indexed by the current entry; entries past the end read as zero.
    always_comb begin
        table_word = 16'h0000;
        case (reg_index)
            8'd0:    table_word = 16'h4110;
            8'd1:    table_word = 16'h9803;
            8'd2:    table_word = 16'h9AE0;
            8'd3:    table_word = 16'h9C30;
            8'd4:    table_word = 16'h9D61;
            8'd5:    table_word = 16'hA2A4;
            8'd6:    table_word = 16'hA3A4;
            8'd7:    table_word = 16'hE0D0;
            8'd8:    table_word = 16'hF900;
            8'd9:    table_word = 16'h1500;
            8'd10:   table_word = 16'h1630;
            8'd11:   table_word = 16'h1702;
            8'd12:   table_word = 16'h1800;
            8'd13:   table_word = 16'hAF06;
            8'd14:   table_word = 16'hD6C0;
            default: table_word = 16'h0000;
        endcase
        if ({1'b0, reg_index} >= NREG) begin
            table_word = 16'h0000;
        end
    end

    // Next-state and datapath update for the sequencer, plus the start pulse.
    always_comb begin
        state_d   = state;
        pwr_cnt_d = pwr_cnt;
        timer_d   = timer;
        retry_d   = retry;
        index_d   = reg_index;
        nack_d    = nack_sticky;
        pend_d    = hpd_pend | hpd_rise;
        i2c_start = 1'b0;
        case (state)
            S_PWRUP: begin
                // Any pending hot-plug is serviced by the power-up wait itself.
                pend_d = 1'b0;
                if (!hpd_s2 || hpd_rise) begin
                    pwr_cnt_d = '0;
                end else if (pwr_cnt == PWR_LAST) begin
                    pwr_cnt_d = '0;
                    index_d   = 8'd0;
                    retry_d   = '0;
                    state_d   = S_ISSUE;
                end else begin
                    pwr_cnt_d = pwr_cnt + 1'b1;
                end
            end
            S_ISSUE: begin
                // Start only when the controller is idle. This is also how a timed-out
                // retry waits for a stuck controller to come back.
                if (i2c_stop) begin
                    i2c_start = 1'b1;
                    nack_d    = 1'b0;
                    timer_d   = 8'd0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                nack_d  = nack_sticky | i2c_ack;
                timer_d = timer + 8'd1;
                if (!i2c_stop) begin
                    state_d = S_CHECK;
                end else if (timer == TO_LAST) begin
                    state_d = S_RETRY;
                end
            end
            S_CHECK: begin
                // A hot-plug that arrived during the transfer is acted on here, after the
                // controller has finished.
                if (hpd_pend) begin
                    pend_d    = 1'b0;
                    index_d   = 8'd0;
                    retry_d   = '0;
                    pwr_cnt_d = '0;
                    state_d   = S_PWRUP;
                end else if (nack_sticky) begin
                    state_d = S_RETRY;
                end else if (reg_index == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    index_d = reg_index + 8'd1;
                    retry_d = '0;
                    state_d = S_ISSUE;
                end
            end
            S_RETRY: begin
                if (retry < RMAX) begin
                    retry_d = retry + 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_DONE, S_ERROR: begin
                if (hpd_pend) begin
                    pend_d    = 1'b0;
                    index_d   = 8'd0;
                    retry_d   = '0;
                    pwr_cnt_d = '0;
                    state_d   = S_PWRUP;
                end
            end
            default: begin
                state_d = S_PWRUP;
            end
        endcase
    end

    // State, counters, and the hpd synchroniser. All of them return to reset values at
    // once when MR_n goes low.
    always_ff @(posedge clock_100khz or negedge MR_n) begin
        if (!MR_n) begin
            state       <= S_PWRUP;
            pwr_cnt     <= '0;
            timer       <= 8'd0;
            retry       <= '0;
            reg_index   <= 8'd0;
            nack_sticky <= 1'b0;
            hpd_s1      <= 1'b0;
            hpd_s2      <= 1'b0;
            hpd_q       <= 1'b0;
            hpd_pend    <= 1'b0;
        end else begin
            state       <= state_d;
            pwr_cnt     <= pwr_cnt_d;
            timer       <= timer_d;
            retry       <= retry_d;
            reg_index   <= index_d;
            nack_sticky <= nack_d;
            hpd_s1      <= hpd;
            hpd_s2      <= hpd_s1;
            hpd_q       <= hpd_s2;
            hpd_pend    <= pend_d;
        end
    end

    // Status outputs, decoded from the state. register_data reads as zero during power-up.
    always_comb begin
        config_done   = (state == S_DONE);
        config_error  = (state == S_ERROR);
        slave_address = SLAVE_ADDR;
        fsm_state     = state;
        register_data = (state == S_PWRUP) ? 16'h0000 : table_word;
    end

endmodule

// File: tb/tb_hdmi_config_sequencer.sv
// Directed bench for hdmi_config_sequencer.
// A behavioural I2C controller model answers the start pulses.
// It can NACK a chosen entry, or hang with i2c_stop stuck high.
module tb_hdmi_config_sequencer;

  localparam int P    = 300;  // shortened power-up wait for simulation
  localparam int XFER = 8;    // model transfer length in cycles

  logic        clk = 1'b0;
  logic        mr_n = 1'b0;
  logic        hpd = 1'b1;
  logic        i2c_stop = 1'b1;
  logic        i2c_ack = 1'b0;
  logic        i2c_start;
  logic [15:0] register_data;
  logic [7:0]  slave_address;
  logic [7:0]  reg_index;
  logic        config_done;
  logic        config_error;
  logic [2:0]  fsm_state;

  hdmi_config_sequencer #(.PWRUP_CYCLES(P)) dut (
    .clock_100khz  (clk),
    .MR_n          (mr_n),
    .hpd           (hpd),
    .i2c_stop      (i2c_stop),
    .i2c_ack       (i2c_ack),
    .i2c_start     (i2c_start),
    .register_data (register_data),
    .slave_address (slave_address),
    .reg_index     (reg_index),
    .config_done   (config_done),
    .config_error  (config_error),
    .fsm_state     (fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] table_w [0:14] = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61,
                                  16'hA2A4, 16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500,
                                  16'h1630, 16'h1702, 16'h1800, 16'hAF06, 16'hD6C0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // controller model configuration (written by the stimulus block)
  int nack_idx   = -1;
  int nack_times = 0;    // negative = NACK forever
  bit hang       = 1'b0;

  // controller model state and scoreboard (written by the model only)
  int          start_cnt, done_cnt, nack_used, rem, last_done_cyc;
  bit          prev_start, nack_cur;
  logic [15:0] cap;
  logic [15:0] sent_q[$];
  int          gap_q[$];
  int          start_cyc_q[$];
  int          attempts [0:15];

  // controller model: acts on the negative edge so inputs are stable at the DUT edge
  initial begin
    forever begin
      @(negedge clk);
      if (!mr_n) begin
        start_cnt = 0; done_cnt = 0; nack_used = 0; rem = 0;
        last_done_cyc = -1; prev_start = 1'b0; nack_cur = 1'b0;
        sent_q.delete(); gap_q.delete(); start_cyc_q.delete();
        for (int i = 0; i < 16; i++) attempts[i] = 0;
        i2c_stop = 1'b1;
        i2c_ack  = 1'b0;
      end else begin
        if (i2c_start) begin
          chk("start_legal", {30'd0, i2c_stop, prev_start}, 32'd2);
          start_cnt++;
          sent_q.push_back(register_data);
          start_cyc_q.push_back(cyc);
          if (reg_index < 8'd16) attempts[reg_index[3:0]]++;
          if (last_done_cyc >= 0) gap_q.push_back(cyc - last_done_cyc);
          cap = register_data;
          rem = XFER;
          nack_cur = (int'(reg_index) == nack_idx) && (nack_times < 0 || nack_used < nack_times);
          if (nack_cur) nack_used++;
        end else if (rem > 0) begin
          rem--;
          if (hang) begin
            i2c_stop = 1'b1;
            i2c_ack  = 1'b0;
          end else if (rem == 0) begin
            i2c_stop = 1'b0;
            i2c_ack  = nack_cur;
            done_cnt++;
            last_done_cyc = cyc;
            chk("data_stable", {16'd0, register_data}, {16'd0, cap});
          end else begin
            i2c_ack = nack_cur;
          end
        end else begin
          i2c_stop = 1'b1;
          i2c_ack  = 1'b0;
        end
        prev_start = i2c_start;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    mr_n = 1'b0;
    repeat (3) tick();
    mr_n = 1'b1;
  endtask

  task automatic wait_start(input int target, input int limit);
    int k = 0;
    while (start_cnt < target && k < limit) begin
      tick();
      k++;
    end
    chk("wait_start", {31'd0, start_cnt >= target}, 32'd1);
  endtask

  task automatic wait_end(input int limit);
    int k = 0;
    while (!config_done && !config_error && k < limit) begin
      tick();
      k++;
    end
    chk("wait_end", {31'd0, config_done | config_error}, 32'd1);
  endtask

  // directed stimulus
  initial begin
    int k;
    mr_n = 1'b0;
    hpd  = 1'b1;
    repeat (3) tick();

    // reset values
    chk("rst_start", {31'd0, i2c_start}, 32'd0);
    chk("rst_index", {24'd0, reg_index}, 32'd0);
    chk("rst_data", {16'd0, register_data}, 32'd0);
    chk("rst_slave", {24'd0, slave_address}, 32'h72);
    chk("rst_done", {31'd0, config_done}, 32'd0);
    chk("rst_error", {31'd0, config_error}, 32'd0);
    chk("rst_state", {29'd0, fsm_state}, 32'd0);

    // 1: all ACK
    mr_n = 1'b1;
    k = 0;
    while (!i2c_start && k < P + 50) begin
      tick();
      k++;
    end
    chk("t1_first_start_latency", k, P + 3);
    wait_end(P + 500);
    chk("t1_done", {31'd0, config_done}, 32'd1);
    chk("t1_error", {31'd0, config_error}, 32'd0);
    chk("t1_starts", start_cnt, 15);
    chk("t1_sent_count", sent_q.size(), 15);
    for (int i = 0; i < 15; i++) chk("t1_data", {16'd0, sent_q[i]}, {16'd0, table_w[i]});
    chk("t1_entry_gap", gap_q[13], 2);
    repeat (50) tick();
    chk("t1_no_more_starts", start_cnt, 15);
    chk("t1_index", {24'd0, reg_index}, 32'd14);

    // 2: NACK on entry 3 once
    nack_idx = 3; nack_times = 1;
    do_reset();
    wait_end(P + 600);
    chk("t2_done", {31'd0, config_done}, 32'd1);
    chk("t2_error", {31'd0, config_error}, 32'd0);
    chk("t2_starts", start_cnt, 16);
    chk("t2_attempts3", attempts[3], 2);
    chk("t2_sent3", {16'd0, sent_q[3]}, 32'h9C30);
    chk("t2_sent4", {16'd0, sent_q[4]}, 32'h9C30);
    chk("t2_sent5", {16'd0, sent_q[5]}, 32'h9D61);
    chk("t2_sent15", {16'd0, sent_q[15]}, 32'hD6C0);

    // 3: NACK on entry 5 always
    nack_idx = 5; nack_times = -1;
    do_reset();
    wait_end(P + 1000);
    chk("t3_error", {31'd0, config_error}, 32'd1);
    chk("t3_done", {31'd0, config_done}, 32'd0);
    chk("t3_starts", start_cnt, 9);
    chk("t3_attempts5", attempts[5], 4);
    chk("t3_index", {24'd0, reg_index}, 32'd5);
    repeat (300) tick();
    chk("t3_no_more_starts", start_cnt, 9);
    chk("t3_error_held", {31'd0, config_error}, 32'd1);

    // 4: controller never finishes
    nack_idx = -1; nack_times = 0; hang = 1'b1;
    do_reset();
    wait_end(P + 1500);
    chk("t4_error", {31'd0, config_error}, 32'd1);
    chk("t4_starts", start_cnt, 4);
    chk("t4_attempts0", attempts[0], 4);
    chk("t4_timeout_gap1", start_cyc_q[1] - start_cyc_q[0], 202);
    chk("t4_timeout_gap3", start_cyc_q[3] - start_cyc_q[2], 202);

    // 5: hot-plug bounce during entry 7, then again from DONE
    hang = 1'b0;
    do_reset();
    wait_start(8, P + 300);
    hpd = 1'b0;
    tick();
    tick();
    hpd = 1'b1;
    wait_end(2 * P + 600);
    chk("t5_done", {31'd0, config_done}, 32'd1);
    chk("t5_starts", start_cnt, 23);
    chk("t5_completed", done_cnt, 23);
    chk("t5_sent7", {16'd0, sent_q[7]}, 32'hE0D0);
    chk("t5_sent8_restart", {16'd0, sent_q[8]}, 32'h4110);
    chk("t5_gap_normal", gap_q[6], 2);
    chk("t5_gap_pwrup", gap_q[7], P + 2);
    hpd = 1'b0;
    repeat (3) tick();
    hpd = 1'b1;
    repeat (5) tick();
    chk("t5_done_cleared", {31'd0, config_done}, 32'd0);
    chk("t5_state_pwrup", {29'd0, fsm_state}, 32'd0);
    chk("t5_index_cleared", {24'd0, reg_index}, 32'd0);
    wait_end(P + 600);
    chk("t5_done_again", {31'd0, config_done}, 32'd1);
    chk("t5_starts_again", start_cnt, 38);

    // 6: MR_n pulsed mid-WAIT
    do_reset();
    wait_start(4, P + 200);
    repeat (3) tick();
    chk("t6_index_pre", {24'd0, reg_index}, 32'd3);
    chk("t6_state_pre", {29'd0, fsm_state}, 32'd2);
    mr_n = 1'b0;
    #1;
    chk("t6_start", {31'd0, i2c_start}, 32'd0);
    chk("t6_index", {24'd0, reg_index}, 32'd0);
    chk("t6_done", {31'd0, config_done}, 32'd0);
    chk("t6_error", {31'd0, config_error}, 32'd0);
    chk("t6_state", {29'd0, fsm_state}, 32'd0);
    chk("t6_data", {16'd0, register_data}, 32'd0);
    repeat (2) tick();
    mr_n = 1'b1;
    wait_end(P + 600);
    chk("t6_rerun_done", {31'd0, config_done}, 32'd1);
    chk("t6_rerun_starts", start_cnt, 15);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
